dac_spi_tx: RTL and testbench
=============================

// Module: dac_spi_tx
// PURPOSE
//  Consumes the filtered per-channel output stream (dv/chan/data) from the output filter and transmits
//  each update to a multi-channel SPI DAC. Keeps one pending slot per channel; newer values overwrite
//  older unsent ones. Round-robin arbitration across pending channels; frames shifted MSB first.
// PARAMETERS
//  N_CHAN   8     number of DAC channels; chan_in >= N_CHAN is ignored
//  W_CHAN   5     channel index width
//  W_DATA   16    data width; frame data field is W_DATA bits
//  CLK_DIV  2     clk_in cycles per sclk half-period (>=1)
//  CS_GAP   4     clk_in cycles cs_n held high between frames (>=1)
//  CMD      4'h3  command nibble (write-and-update)
// PORTS
//  clk_in         in   1        system clock
//  rst_in         in   1        asynchronous, active-high reset
//  dv_in          in   1        data valid, one-cycle strobe per sample
//  chan_in        in   W_CHAN   channel of data_in
//  data_in        in   W_DATA   signed two's-complement output value
//  spi_sclk_out   out  1        SPI clock, idles low
//  spi_cs_n_out   out  1        SPI chip select, active low
//  spi_mosi_out   out  1        SPI data, changes on sclk falling edge, DAC samples on rising edge
//  busy_out       out  1        high from LOAD through end of GAP
//  done_out       out  1        one-cycle pulse when a frame completes
//  done_chan_out  out  W_CHAN   channel of completed frame, valid with done_out
// BEHAVIOUR
//  Reset: sclk=0, cs_n=1, mosi=0, busy=0, done=0, done_chan=0. All pending flags cleared, rr_ptr=0,
//   FSM=IDLE. Reset asserted mid-frame aborts it at once: cs_n rises asynchronously, pending data lost.
//  Intake: on a clk edge with dv_in=1 and chan_in<N_CHAN: val[chan]<=data_in, pend[chan]<=1.
//   dv_in is accepted every cycle, in every state (no backpressure).
//  Frame (24b) = {CMD, chan[3:0], data ^ (1<<(W_DATA-1))}: MSB inverted, signed -> offset binary.
//  FSM IDLE: if any pend, select the first pending index scanning from rr_ptr upward with wrap -> LOAD.
//  FSM LOAD (1 cycle): shreg<=frame, pend[sel]<=0, cs_n<=0, mosi<=frame[23], sclk=0 -> SHIFT.
//   If dv_in writes the selected channel in the LOAD cycle, set wins: pend stays 1, and this frame
//   carries the old value.
//  FSM SHIFT: sclk toggles every CLK_DIV cycles, starting low. Each falling edge presents the next
//   bit on mosi. After the 24th rising edge, sclk falls after CLK_DIV cycles, and cs_n rises on the
//   same edge -> GAP. The SHIFT state lasts exactly 48*CLK_DIV cycles.
//  FSM GAP: done_out=1 and done_chan_out=sel on the first GAP cycle only. rr_ptr<=(sel+1)%N_CHAN.
//   GAP holds cs_n high for CS_GAP cycles -> IDLE.
//  Latency, idle block: dv_in sampled at edge k -> cs_n low at edge k+2.
//   Total busy per frame = 1 + 48*CLK_DIV + CS_GAP cycles.
//  Data arriving during a frame is held in pend and sent after GAP. Multiple writes to one channel
//   coalesce to the last value.
//  Back-to-back pending frames: IDLE lasts one cycle between GAP and LOAD.
// TESTING
//  1 Single write: ch2, data 16'sh0001, CLK_DIV=2.
//    -> cs_n low 2 cycles after dv, 24 sclk pulses, mosi stream 0x328001, done_out ch2 after 97 cycles.
//  2 Arithmetic edge: ch0 data -32768, then ch0 data 32767.
//    -> frames 0x300000 and 0x30FFFF.
//  3 Coalesce: ch1 ← 0x0100 (starts frame), then ch1 ← 0x0200, 0x0300 during frame.
//    -> exactly 2 frames: data 0x8100 then 0x8300.
//  4 Round robin: while busy on ch5, write ch0, ch3, ch7.
//    -> send order ch7, ch0, ch3. Invalid write chan_in=12 produces no frame.
//  5 Collision: dv_in to selected channel in the LOAD cycle.
//    -> old value sent, new value sent in the next frame.
//  6 Reset mid-frame at bit 10: cs_n=1, sclk=0 immediately. No done_out.
//    After release, idle until new dv_in.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx
//   Takes the filtered per-channel sample stream (dv/chan/data) and ships each
//   update to a multi-channel SPI DAC. Each channel has a single pending slot.
//   A newer sample overwrites an older one that has not been sent yet. Pending
//   channels are served round-robin. Each frame is {CMD, chan[3:0], offset-binary
//   data} and is shifted out MSB first.
//
// Ports
//   clk_in        system clock
//   rst_in        asynchronous active-high reset (aborts any frame in flight)
//   dv_in         one-cycle sample strobe, accepted in every state
//   chan_in       channel of data_in; values >= N_CHAN are ignored
//   data_in       signed two's-complement sample
//   spi_sclk_out  SPI clock, idles low
//   spi_cs_n_out  SPI chip select, active low
//   spi_mosi_out  SPI data, changes after sclk falls
//   busy_out      high from LOAD through the end of GAP
//   done_out      one-cycle pulse on the first GAP cycle
//   done_chan_out channel of the frame that just completed
module dac_spi_tx #(
    parameter int          N_CHAN  = 8,
    parameter int          W_CHAN  = 5,
    parameter int          W_DATA  = 16,
    parameter int          CLK_DIV = 2,
    parameter int          CS_GAP  = 4,
    parameter logic [3:0]  CMD     = 4'h3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dv_in,
    input  logic [W_CHAN-1:0] chan_in,
    input  logic [W_DATA-1:0] data_in,
    output logic              spi_sclk_out,
    output logic              spi_cs_n_out,
    output logic              spi_mosi_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [W_CHAN-1:0] done_chan_out
);

    localparam int W_FRAME = 8 + W_DATA;
    localparam int N_HALF  = 2 * W_FRAME;
    localparam int W_DIV   = $clog2(CLK_DIV + 1);
    localparam int W_HALF  = $clog2(N_HALF);
    localparam int W_GAP   = $clog2(CS_GAP + 1);

    localparam logic [W_DIV-1:0]  DIV_LAST  = W_DIV'(CLK_DIV - 1);
    localparam logic [W_HALF-1:0] HALF_LAST = W_HALF'(N_HALF - 1);
    localparam logic [W_GAP-1:0]  GAP_LAST  = W_GAP'(CS_GAP - 1);
    localparam logic [W_CHAN-1:0] CHAN_LAST = W_CHAN'(N_CHAN - 1);
    localparam logic [W_CHAN:0]   N_CHAN_W  = (W_CHAN + 1)'(N_CHAN);
    localparam logic [W_DATA-1:0] SIGN_FLIP = {1'b1, {(W_DATA-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t              r_state, w_state_next;
    logic [N_CHAN-1:0]   r_pend;
    logic [W_DATA-1:0]   r_val [N_CHAN];
    logic [W_CHAN-1:0]   r_sel;
    logic [W_CHAN-1:0]   r_rr_ptr;
    logic [W_FRAME-1:0]  r_shreg;
    logic                r_sclk, r_cs_n, r_mosi;
    logic [W_DIV-1:0]    r_div_cnt;
    logic [W_HALF-1:0]   r_half_cnt;
    logic [W_GAP-1:0]    r_gap_cnt;
    logic                r_done;
    logic [W_CHAN-1:0]   r_done_chan;

    logic [N_CHAN-1:0]   w_rot;
    logic [W_CHAN-1:0]   w_arb_sel;
    logic [W_DATA-1:0]   w_sel_val;
    logic [W_FRAME-1:0]  w_frame;
    logic                w_tick, w_last;

    // Pending flags rotated so bit 0 is the rr_ptr channel; the lowest set bit
    // is the next channel to serve.
    assign w_rot = N_CHAN'({r_pend, r_pend} >> r_rr_ptr);

    always_comb begin : arb
        logic [W_CHAN:0] sum;
        sum       = '0;
        w_arb_sel = '0;
        // Descending scan so the lowest rotated index is the one that sticks.
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                sum = {1'b0, r_rr_ptr} + (W_CHAN + 1)'(i);
                if (sum >= N_CHAN_W) sum = sum - N_CHAN_W;
                w_arb_sel = W_CHAN'(sum);
            end
        end
    end

    always_comb begin
        w_sel_val = '0;
        for (int c = 0; c < N_CHAN; c++)
            if (r_sel == W_CHAN'(c)) w_sel_val = r_val[c];
    end

    // Inverting the MSB turns two's complement into offset binary.
    assign w_frame = {CMD, r_sel[3:0], w_sel_val ^ SIGN_FLIP};

    assign w_tick = (r_state == S_SHIFT) && (r_div_cnt == DIV_LAST);
    // Final sclk fall: the one after the last rising edge ends the frame.
    assign w_last = w_tick && r_sclk && (r_half_cnt == HALF_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (|r_pend) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_GAP;
            S_GAP:   if (r_gap_cnt == GAP_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Intake. The LOAD clear comes first so a write to the selected channel
    // in the same cycle keeps the flag set; the frame still latches the old value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pend <= '0;
            for (int c = 0; c < N_CHAN; c++) r_val[c] <= '0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (r_state == S_LOAD && r_sel == W_CHAN'(c)) r_pend[c] <= 1'b0;
                if (dv_in && chan_in == W_CHAN'(c)) begin
                    r_pend[c] <= 1'b1;
                    r_val[c]  <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_shreg     <= '0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_div_cnt   <= '0;
            r_half_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_done      <= 1'b0;
            r_done_chan <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (|r_pend) r_sel <= w_arb_sel;
                S_LOAD: begin
                    r_shreg    <= w_frame;
                    r_mosi     <= w_frame[W_FRAME-1];
                    r_cs_n     <= 1'b0;
                    r_sclk     <= 1'b0;
                    r_div_cnt  <= '0;
                    r_half_cnt <= '0;
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_div_cnt  <= '0;
                        r_sclk     <= ~r_sclk;
                        r_half_cnt <= r_half_cnt + 1'b1;
                        if (r_sclk) begin
                            if (w_last) begin
                                r_cs_n      <= 1'b1;
                                r_mosi      <= 1'b0;
                                r_done      <= 1'b1;
                                r_done_chan <= r_sel;
                                r_rr_ptr    <= (r_sel == CHAN_LAST) ? '0 : r_sel + 1'b1;
                                r_gap_cnt   <= '0;
                            end else begin
                                // Falling edge: present the next bit.
                                r_shreg <= {r_shreg[W_FRAME-2:0], 1'b0};
                                r_mosi  <= r_shreg[W_FRAME-2];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign spi_sclk_out  = r_sclk;
    assign spi_cs_n_out  = r_cs_n;
    assign spi_mosi_out  = r_mosi;
    assign busy_out      = (r_state != S_IDLE);
    assign done_out      = r_done;
    assign done_chan_out = r_done_chan;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx
//   Directed bench for dac_spi_tx: a vector table of single writes with
//   hand-computed frames, plus sequences for latency, coalescing, round-robin,
//   the LOAD-cycle collision and reset mid-frame. A negedge monitor rebuilds
//   each frame from sclk/mosi/cs_n and records done pulses.
module tb_dac_spi_tx;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        dv_in = 1'b0;
    logic [4:0]  chan_in = '0;
    logic [15:0] data_in = '0;
    logic        spi_sclk_out, spi_cs_n_out, spi_mosi_out;
    logic        busy_out, done_out;
    logic [4:0]  done_chan_out;

    dac_spi_tx dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .dv_in         (dv_in),
        .chan_in       (chan_in),
        .data_in       (data_in),
        .spi_sclk_out  (spi_sclk_out),
        .spi_cs_n_out  (spi_cs_n_out),
        .spi_mosi_out  (spi_mosi_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .done_chan_out (done_chan_out)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

    // Frame monitor
    logic [23:0] fq[$];
    logic [4:0]  dq[$];
    logic [23:0] shf = '0;
    int          nbits = 0;
    int          aborted = 0;
    logic        p_sclk = 1'b0;
    logic        p_cs = 1'b1;

    always @(negedge clk_in) begin
        if (!spi_cs_n_out && spi_sclk_out && !p_sclk) begin
            shf = {shf[22:0], spi_mosi_out};
            nbits++;
        end
        if (spi_cs_n_out && !p_cs) begin
            if (nbits == 24) fq.push_back(shf);
            else if (nbits > 0) aborted++;
            nbits = 0;
        end
        if (done_out) dq.push_back(done_chan_out);
        p_sclk = spi_sclk_out;
        p_cs   = spi_cs_n_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic write(input logic [4:0] c, input logic [15:0] d);
        @(negedge clk_in);
        dv_in = 1'b1; chan_in = c; data_in = d;
        @(negedge clk_in);
        dv_in = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (fq.size() < n && t < 4000) begin @(negedge clk_in); t++; end
        if (fq.size() < n) begin
            n_total++;
            $display("FAIL wait_frames: got %0d frames expected %0d", fq.size(), n);
        end
    endtask

    task automatic wait_cs_low();
        int t = 0;
        while (spi_cs_n_out && t < 100) begin @(negedge clk_in); t++; end
        if (spi_cs_n_out) begin
            n_total++;
            $display("FAIL wait_cs_low: cs_n still 1 expected 0");
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_out && t < 4000) begin @(negedge clk_in); t++; end
        if (busy_out) begin
            n_total++;
            $display("FAIL wait_idle: busy still 1 expected 0");
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic chk_frame(input string name, input int idx, input logic [23:0] exp);
        if (idx < fq.size()) chk(name, 32'(fq[idx]), 32'(exp));
        else begin n_total++; $display("FAIL %s: frame %0d missing expected 0x%0h", name, idx, exp); end
    endtask

    task automatic chk_done(input string name, input int idx, input logic [4:0] exp);
        if (idx < dq.size()) chk(name, 32'(dq[idx]), 32'(exp));
        else begin n_total++; $display("FAIL %s: done %0d missing expected %0d", name, idx, exp); end
    endtask

    typedef struct {
        logic [4:0]  ch;
        logic [15:0] d;
        logic [23:0] f;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int fi, cyc, n0, d0;

        tbl[0] = '{ch: 5'd2, d: 16'h0001, f: 24'h328001};
        tbl[1] = '{ch: 5'd0, d: 16'h8000, f: 24'h300000};  // -32768
        tbl[2] = '{ch: 5'd0, d: 16'h7FFF, f: 24'h30FFFF};  // 32767
        tbl[3] = '{ch: 5'd7, d: 16'h1234, f: 24'h379234};
        tbl[4] = '{ch: 5'd5, d: 16'hFFFF, f: 24'h357FFF};  // -1
        tbl[5] = '{ch: 5'd3, d: 16'hA5A5, f: 24'h3325A5};

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_sclk", 32'(spi_sclk_out), 0);
        chk("rst_cs_n", 32'(spi_cs_n_out), 1);
        chk("rst_mosi", 32'(spi_mosi_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_done_chan", 32'(done_chan_out), 0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // Single write: latency and frame timing
        write(5'd2, 16'h0001);                    // dv sampled at edge k
        chk("lat_k_cs", 32'(spi_cs_n_out), 1);
        @(negedge clk_in);                        // after k+1: LOAD
        chk("lat_k1_cs", 32'(spi_cs_n_out), 1);
        chk("load_busy", 32'(busy_out), 1);
        cyc = 0;
        @(negedge clk_in); cyc++;                 // after k+2
        chk("lat_k2_cs", 32'(spi_cs_n_out), 0);
        while (!done_out && cyc < 300) begin @(negedge clk_in); cyc++; end
        chk("done_cycles", 32'(cyc), 97);
        chk("done_chan_t1", 32'(done_chan_out), 2);
        chk("cs_at_done", 32'(spi_cs_n_out), 1);
        @(negedge clk_in); cyc++;
        chk("done_pulse", 32'(done_out), 0);
        while (busy_out && cyc < 400) begin @(negedge clk_in); cyc++; end
        chk("busy_cycles", 32'(cyc), 101);
        chk_frame("frame_t1", 0, 24'h328001);
        fi = 1;
        wait_idle();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            write(tbl[i].ch, tbl[i].d);
            wait_frames(fi + 1);
            chk_frame($sformatf("tbl%0d_frame", i), fi, tbl[i].f);
            chk_done($sformatf("tbl%0d_done", i), fi, tbl[i].ch);
            fi++;
            wait_idle();
        end

        // Coalesce
        write(5'd1, 16'h0100);
        wait_cs_low();
        write(5'd1, 16'h0200);
        write(5'd1, 16'h0300);
        wait_frames(fi + 2);
        chk_frame("coal_f0", fi, 24'h318100);
        chk_frame("coal_f1", fi + 1, 24'h318300);
        repeat (300) @(negedge clk_in);
        chk("coal_count", 32'(fq.size()), 32'(fi + 2));
        fi += 2;
        wait_idle();

        // Round robin plus an out-of-range channel
        write(5'd5, 16'h0005);
        wait_cs_low();
        write(5'd0, 16'h0000);
        write(5'd3, 16'h0003);
        write(5'd7, 16'h0007);
        write(5'd12, 16'hDEAD);
        wait_frames(fi + 4);
        chk_frame("rr_f0", fi,     24'h358005);
        chk_frame("rr_f1", fi + 1, 24'h378007);
        chk_frame("rr_f2", fi + 2, 24'h308000);
        chk_frame("rr_f3", fi + 3, 24'h338003);
        chk_done("rr_d1", fi + 1, 5'd7);
        chk_done("rr_d2", fi + 2, 5'd0);
        chk_done("rr_d3", fi + 3, 5'd3);
        repeat (400) @(negedge clk_in);
        chk("rr_count", 32'(fq.size()), 32'(fi + 4));
        fi += 4;
        wait_idle();

        // Collision in the LOAD cycle
        write(5'd4, 16'h1111);                    // after edge k
        @(negedge clk_in);                        // after k+1: LOAD
        chk("col_load_busy", 32'(busy_out), 1);
        chk("col_load_cs", 32'(spi_cs_n_out), 1);
        dv_in = 1'b1; chan_in = 5'd4; data_in = 16'h2222;   // sampled at k+2
        @(negedge clk_in);
        dv_in = 1'b0;
        wait_frames(fi + 2);
        chk_frame("col_f0", fi, 24'h349111);
        chk_frame("col_f1", fi + 1, 24'h34A222);
        fi += 2;
        wait_idle();

        // Reset mid-frame at bit 10
        n0 = fq.size();
        d0 = dq.size();
        write(5'd6, 16'h4321);
        cyc = 0;
        while (nbits < 10 && cyc < 500) begin @(negedge clk_in); cyc++; end
        chk("rst_mid_reached", 32'(nbits), 10);
        #3 rst_in = 1'b1;
        #1;
        chk("rst_mid_cs", 32'(spi_cs_n_out), 1);
        chk("rst_mid_sclk", 32'(spi_sclk_out), 0);
        chk("rst_mid_busy", 32'(busy_out), 0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (300) @(negedge clk_in);
        chk("rst_no_frame", 32'(fq.size()), 32'(n0));
        chk("rst_no_done", 32'(dq.size()), 32'(d0));
        chk("rst_aborted", 32'(aborted), 1);
        chk("rst_idle_cs", 32'(spi_cs_n_out), 1);
        chk("rst_idle_busy", 32'(busy_out), 0);
        write(5'd6, 16'h0001);
        wait_frames(n0 + 1);
        chk_frame("rst_recover", n0, 24'h368001);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
